// File: rtl/uart_image_rx.sv
// uart_image_rx: 8N1 UART receiver that writes one byte per pixel, in raster
// order, into the CNN image buffer and flags image_ready once a full
// IMAGE_SIZE x IMAGE_SIZE image has been stored.
module uart_image_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned IMAGE_SIZE   = 28,
  parameter int unsigned PIXEL_DEPTH  = 8,
  parameter int unsigned ADDR_WIDTH   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   RxD,
  input  logic                   image_ack,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [PIXEL_DEPTH-1:0] wr_data,
  output logic                   image_ready,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(IMAGE_SIZE * IMAGE_SIZE - 1);
  localparam logic [2:0] LAST_BIT = 3'(PIXEL_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t state, next_state;

  logic                   rx_meta, rx_s;
  logic [CW-1:0]          baud_cnt;
  logic [2:0]             bit_idx;
  logic [PIXEL_DEPTH-1:0] shreg;
  logic [ADDR_WIDTH-1:0]  pix_cnt;

  logic tick;
  logic load_half, load_full;
  logic sample_bit;
  logic do_write, do_ovr, do_ferr;

  assign tick = (baud_cnt == '0);
  assign busy = (state != IDLE);

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rx_s    <= rx_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic and one-cycle datapath controls.
  always_comb begin
    next_state = state;
    load_half  = 1'b0;
    load_full  = 1'b0;
    sample_bit = 1'b0;
    do_write   = 1'b0;
    do_ovr     = 1'b0;
    do_ferr    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          load_half  = 1'b1;
          next_state = START;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            load_full  = 1'b1;
            next_state = DATA;
          end else begin
            next_state = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          sample_bit = 1'b1;
          load_full  = 1'b1;
          if (bit_idx == LAST_BIT) next_state = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (!rx_s) begin
            do_ferr    = 1'b1;
            next_state = WAIT_IDLE;
          end else begin
            if (image_ready) do_ovr = 1'b1;
            else             do_write = 1'b1;
            next_state = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Baud counter: half-bit load from IDLE, full-bit reload at each sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              baud_cnt <= '0;
    else if (load_half)   baud_cnt <= HALF_LOAD;
    else if (load_full)   baud_cnt <= FULL_LOAD;
    else if (baud_cnt != '0) baud_cnt <= baud_cnt - 1'b1;
  end

  // Bit index and LSB-first shift register; index restarts on a valid start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx <= '0;
      shreg   <= '0;
    end else if (state == START) begin
      bit_idx <= '0;
    end else if (sample_bit) begin
      shreg[bit_idx] <= rx_s;
      bit_idx        <= bit_idx + 1'b1;
    end
  end

  // Write port, pixel counter and status pulses, registered one cycle after
  // the stop-bit sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      pix_cnt   <= '0;
    end else begin
      wr_en     <= do_write;
      frame_err <= do_ferr;
      overrun   <= do_ovr;
      if (do_write) begin
        wr_addr <= pix_cnt;
        wr_data <= shreg;
        if (pix_cnt == LAST_PIX) pix_cnt <= '0;
        else                     pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

  // Sticky completion flag; a completing write takes priority over image_ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                image_ready <= 1'b0;
    else if (do_write && pix_cnt == LAST_PIX) image_ready <= 1'b1;
    else if (image_ack)                     image_ready <= 1'b0;
  end

endmodule

// File: tb/tb_uart_image_rx.sv
// tb_uart_image_rx: directed bench for uart_image_rx with CLKS_PER_BIT=16,
// IMAGE_SIZE=4.
module tb_uart_image_rx;

  localparam int unsigned CPB = 16;
  localparam int unsigned IMS = 4;
  localparam int unsigned AW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          RxD = 1'b1;
  logic          image_ack = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          image_ready;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  uart_image_rx #(
    .CLKS_PER_BIT(CPB),
    .IMAGE_SIZE  (IMS),
    .PIXEL_DEPTH (8),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RxD        (RxD),
    .image_ack  (image_ack),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .image_ready(image_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntotal = 0;

  int nwr = 0;
  int nfe = 0;
  int novr = 0;
  int excl = 0;
  logic [AW-1:0] log_addr  [64];
  logic [7:0]    log_data  [64];
  logic          log_ready [64];

  // Event monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        if (nwr < 64) begin
          log_addr[nwr]  = wr_addr;
          log_data[nwr]  = wr_data;
          log_ready[nwr] = image_ready;
        end
        nwr = nwr + 1;
      end
      if (frame_err) nfe = nfe + 1;
      if (overrun) novr = novr + 1;
      if ((int'(wr_en) + int'(frame_err) + int'(overrun)) > 1) excl = excl + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    RxD = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    RxD = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(3);
  endtask

  int base_wr, base_fe, base_ovr, waited;

  initial begin
    // Reset state
    @(negedge clk);
    idle(2);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_image_ready", 32'(image_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", {30'd0, frame_err, overrun}, 32'd0);
    rst = 1'b0;
    idle(3);

    // Single byte 0xA5
    send_byte(8'hA5);
    idle(4);
    chk("single_nwr", 32'(nwr), 32'd1);
    chk("single_addr", 32'(log_addr[0]), 32'd0);
    chk("single_data", 32'(log_data[0]), 32'hA5);
    chk("single_ferr", 32'(nfe), 32'd0);
    chk("single_ready", 32'(image_ready), 32'd0);

    // Full image 0x00..0x0F back-to-back
    do_reset();
    base_wr = nwr;
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    idle(4);
    chk("full_nwr", 32'(nwr - base_wr), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("full_addr_%0d", i), 32'(log_addr[base_wr + i]), 32'(i));
      chk($sformatf("full_data_%0d", i), 32'(log_data[base_wr + i]), 32'(i));
    end
    chk("full_ready_at_15", 32'(log_ready[base_wr + 15]), 32'd1);
    chk("full_ready_at_14", 32'(log_ready[base_wr + 14]), 32'd0);
    chk("full_ready_now", 32'(image_ready), 32'd1);

    // Overrun while image_ready
    base_wr = nwr;
    base_ovr = novr;
    send_byte(8'h3C);
    idle(4);
    chk("ovr_count", 32'(novr - base_ovr), 32'd1);
    chk("ovr_no_write", 32'(nwr - base_wr), 32'd0);
    chk("ovr_ready_held", 32'(image_ready), 32'd1);

    // Ack clears, next byte lands at address 0 (counter wrapped)
    image_ack = 1'b1;
    @(negedge clk);
    image_ack = 1'b0;
    chk("ack_clears", 32'(image_ready), 32'd0);
    base_wr = nwr;
    send_byte(8'h77);
    idle(4);
    chk("ack_nwr", 32'(nwr - base_wr), 32'd1);
    chk("ack_addr", 32'(log_addr[base_wr]), 32'd0);
    chk("ack_data", 32'(log_data[base_wr]), 32'h77);
    chk("ack_ready", 32'(image_ready), 32'd0);

    // Framing error: stop bit low for 3 bit times
    do_reset();
    base_wr = nwr;
    base_fe = nfe;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(((8'h55 >> i) & 8'h01) != 0);
    RxD = 1'b0;
    repeat (3 * CPB - 2) @(negedge clk);
    chk("ferr_count", 32'(nfe - base_fe), 32'd1);
    chk("ferr_wait_busy", 32'(busy), 32'd1);
    chk("ferr_no_write", 32'(nwr - base_wr), 32'd0);
    RxD = 1'b1;
    idle(CPB);
    chk("ferr_back_idle", 32'(busy), 32'd0);
    send_byte(8'h11);
    idle(4);
    chk("ferr_next_nwr", 32'(nwr - base_wr), 32'd1);
    chk("ferr_next_addr", 32'(log_addr[base_wr]), 32'd0);
    chk("ferr_next_data", 32'(log_data[base_wr]), 32'h11);
    chk("ferr_count_total", 32'(nfe - base_fe), 32'd1);

    // Glitch: low for 4 clk then high
    base_wr = nwr;
    base_fe = nfe;
    base_ovr = novr;
    RxD = 1'b0;
    idle(4);
    chk("glitch_busy_rose", 32'(busy), 32'd1);
    RxD = 1'b1;
    waited = 0;
    while (busy && waited < int'(CPB / 2 + 3)) begin
      @(negedge clk);
      waited++;
    end
    chk("glitch_busy_fell", 32'(busy), 32'd0);
    idle(CPB);
    chk("glitch_no_events", 32'((nwr - base_wr) + (nfe - base_fe) + (novr - base_ovr)), 32'd0);

    // Reset mid-byte during data bit 4 of 0xFF
    base_wr = nwr;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    RxD = 1'b1;
    idle(CPB / 2);
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", 32'(wr_data), 32'd0);
    chk("mid_rst_outs", {27'd0, wr_en, image_ready, frame_err, overrun, 1'b0}, 32'd0);
    idle(3);
    rst = 1'b0;
    idle(CPB);
    chk("mid_no_write", 32'(nwr - base_wr), 32'd0);
    send_byte(8'h81);
    idle(4);
    chk("mid_next_nwr", 32'(nwr - base_wr), 32'd1);
    chk("mid_next_addr", 32'(log_addr[base_wr]), 32'd0);
    chk("mid_next_data", 32'(log_data[base_wr]), 32'h81);

    chk("exclusive_strobes", 32'(excl), 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_image_rx.md
Name: uart_image_rx

Overview:
- UART receiver that loads one input image into the CNN image buffer over a serial line.
- It is the receiving counterpart of the CNN TxD transmit path and shares its 8N1 framing.
- Each received byte is one pixel, stored in raster order. Pixel 0 is the top-left pixel.
- After IMAGE_SIZE*IMAGE_SIZE pixels have been written, it flags image_ready so the CNN controller can start inference.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); must be ≥ 4.
- IMAGE_SIZE, 28, height and width of the input image.
- PIXEL_DEPTH, 8, bits per pixel; equals the UART data width, fixed at 8.
- ADDR_WIDTH, 10, width of the buffer address; must satisfy 2^ADDR_WIDTH ≥ IMAGE_SIZE^2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- RxD  input  1  serial line; idles high; asynchronous to clk.
- image_ack  input  1  one-cycle pulse from the controller that consumes the image and clears image_ready.
- wr_en  output  1  one-cycle write strobe to the image buffer.
- wr_addr  output  ADDR_WIDTH  pixel index (0 to IMAGE_SIZE^2-1).
- wr_data  output  PIXEL_DEPTH  received pixel value.
- image_ready  output  1  high once a full image has been written; sticky until image_ack.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- overrun  output  1  one-cycle pulse when a byte is dropped because image_ready is high.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst=1):
  - All outputs go to 0; wr_addr=0.
  - FSM goes to IDLE; pixel counter and baud counter clear.
  - The RxD synchronizer resets to 1.
  - Reset asserted mid-byte abandons the partial byte; no write occurs.
- Input sync:
  - RxD passes through 2 flops before use; all sampling uses the synchronized value.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on a synchronized RxD of 0, load baud counter, go to START.
  - START: wait CLKS_PER_BIT/2 cycles (integer divide).
    - Sample low: the bit is a valid start; reload baud counter, go to DATA, bit index 0.
    - Sample high: treat as a glitch; return to IDLE; no flags raised.
  - DATA: every CLKS_PER_BIT cycles, sample a bit into shift register position bit_idx (LSB first). After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample the line.
    - High, image_ready=0: next cycle wr_en=1, wr_data=byte, wr_addr=pixel count; counter increments; go to IDLE.
    - High, image_ready=1: byte discarded; overrun pulses; no write; counter unchanged; go to IDLE.
    - Low: frame_err pulses; byte discarded; counter unchanged; go to WAIT_IDLE.
  - WAIT_IDLE: stay until the synchronized RxD is 1, then go to IDLE. This blocks break conditions from re-triggering.
- Latency: wr_en asserts exactly 1 clk after the stop-bit sample point. That is about 9.5 bit times after the start edge, plus 2 sync cycles.
- Completion:
  - The write of pixel IMAGE_SIZE^2-1 sets image_ready=1 in the same cycle wr_en=1.
  - The pixel counter wraps to 0 on that write.
- image_ack clears image_ready on the next edge.
  - image_ack while image_ready=0 has no effect.
  - image_ack in the same cycle as a completing write: the set wins; image_ready stays 1.
- wr_en, frame_err and overrun are mutually exclusive and each is high for at most 1 cycle per byte.
- wr_addr and wr_data hold their last written values between strobes.
- busy is combinational: busy = (state != IDLE).

Test Plan (CLKS_PER_BIT=16, IMAGE_SIZE=4):
- Single byte: send 0xA5 after reset -> one wr_en pulse with wr_addr=0, wr_data=0xA5; frame_err=0, image_ready=0.
- Full image: send bytes 0x00 to 0x0F back-to-back -> 16 writes with wr_addr=i, wr_data=i; image_ready rises with the 16th write; counter returns to 0.
- Overrun and ack:
  - With image_ready=1, send 0x3C -> overrun pulses once; no wr_en; image_ready stays 1.
  - Then pulse image_ack, send 0x77 -> image_ready=0; write at wr_addr=0 with wr_data=0x77.
- Framing error: send 0x55 with the stop bit held low for 3 bit times, then line high, then 0x11 -> frame_err pulses once; no write for 0x55; FSM stays in WAIT_IDLE while the line is low; 0x11 is written at wr_addr=0.
- Glitch: drive RxD low for 4 clk, then high -> FSM returns to IDLE; busy deasserts within CLKS_PER_BIT/2+3 cycles; no flags.
- Reset mid-byte: assert rst during DATA bit 4 of 0xFF -> all outputs 0 immediately; after release, send 0x81 -> written at wr_addr=0, wr_data=0x81.
